// File: rtl/gray_pkg.sv
// Shared Gray-code helpers for the counter and the FIFO pointer logic that reuses it.
// Both functions work at MAX_WIDTH. Callers zero-extend their operand and truncate the result.
package gray_pkg;

  localparam int MAX_WIDTH = 16;

  typedef enum logic [1:0] {
    OP_HOLD = 2'd0,
    OP_LOAD = 2'd1,
    OP_UP   = 2'd2,
    OP_DOWN = 2'd3
  } op_e;

  function automatic logic [MAX_WIDTH-1:0] bin2gray(input logic [MAX_WIDTH-1:0] value);
    return value ^ (value >> 1);
  endfunction

  // Zero-extended high bits leave the low bits of the decoded value unchanged.
  function automatic logic [MAX_WIDTH-1:0] gray2bin(input logic [MAX_WIDTH-1:0] value);
    logic [MAX_WIDTH-1:0] b;
    b[MAX_WIDTH-1] = value[MAX_WIDTH-1];
    for (int i = MAX_WIDTH - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ value[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/gray2bin_n.sv
// Combinational Gray-to-binary decoder of generic width.
// Each binary bit is the XOR of all Gray bits at or above it.
module gray2bin_n #(
  parameter int WIDTH = 3
) (
  input  logic [WIDTH-1:0] gray,
  output logic [WIDTH-1:0] bin
);

  // A reduction per bit avoids a self-referencing chain on bin.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
    assign bin[gi] = ^gray[WIDTH-1:gi];
  end

endmodule

// File: rtl/gray_counter_n.sv
// Up/down Gray counter with Gray load, wrap pulse and overflow/underflow flags.
// The state is kept in binary. The Gray output is derived from the registered binary value.
module gray_counter_n
  import gray_pkg::*;
#(
  parameter int WIDTH  = 3,
  parameter int STICKY = 1
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             En,
  input  logic             Dir,
  input  logic             Load,
  input  logic [WIDTH-1:0] LoadVal,
  input  logic             ClrFlags,
  output logic [WIDTH-1:0] Output,
  output logic [WIDTH-1:0] BinOut,
  output logic             Overflow,
  output logic             Underflow,
  output logic             Wrap
);

  logic [WIDTH-1:0] bin_reg, bin_next;
  logic [WIDTH-1:0] load_bin;
  logic             ovf_reg, ovf_next;
  logic             unf_reg, unf_next;
  logic             wrap_reg;
  logic             up_wrap, down_wrap;
  op_e              op;

  gray2bin_n #(.WIDTH(WIDTH)) u_load_dec (
    .gray (LoadVal),
    .bin  (load_bin)
  );

  always_comb begin
    op = OP_HOLD;
    if (Load) begin
      op = OP_LOAD;
    end else if (En) begin
      op = Dir ? OP_UP : OP_DOWN;
    end
  end

  assign up_wrap   = (op == OP_UP)   && (&bin_reg);
  assign down_wrap = (op == OP_DOWN) && (bin_reg == '0);

  always_comb begin
    bin_next = bin_reg;
    case (op)
      OP_LOAD: bin_next = load_bin;
      OP_UP:   bin_next = bin_reg + WIDTH'(1);
      OP_DOWN: bin_next = bin_reg - WIDTH'(1);
      default: bin_next = bin_reg;
    endcase
  end

  // A wrap in the same cycle as ClrFlags keeps its own flag set.
  always_comb begin
    if (STICKY != 0) begin
      ovf_next = up_wrap   | (ovf_reg & ~ClrFlags);
      unf_next = down_wrap | (unf_reg & ~ClrFlags);
    end else begin
      ovf_next = up_wrap;
      unf_next = down_wrap;
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      bin_reg  <= '0;
      ovf_reg  <= 1'b0;
      unf_reg  <= 1'b0;
      wrap_reg <= 1'b0;
    end else begin
      bin_reg  <= bin_next;
      ovf_reg  <= ovf_next;
      unf_reg  <= unf_next;
      wrap_reg <= up_wrap | down_wrap;
    end
  end

  assign Output    = WIDTH'(bin2gray(MAX_WIDTH'(bin_reg)));
  assign BinOut    = bin_reg;
  assign Overflow  = ovf_reg;
  assign Underflow = unf_reg;
  assign Wrap      = wrap_reg;

endmodule

// File: tb/tb_gray_counter_n.sv
// Bench for gray_counter_n. A 3-bit sticky counter and a 5-bit pulse-flag counter share one stimulus stream.
// A behavioural model tracks the count as a plain integer, and directed steps pin known codes.
module tb_gray_counter_n;

  logic       clk = 1'b0;
  logic       rst_n, en, dir, load, clr;
  logic [4:0] load_val;

  logic [2:0] out_a, bin_a;
  logic       ovf_a, unf_a, wrap_a;
  logic [4:0] out_b, bin_b;
  logic       ovf_b, unf_b, wrap_b;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  gray_counter_n #(.WIDTH(3), .STICKY(1)) dut_a (
    .Clk(clk), .Reset(rst_n), .En(en), .Dir(dir), .Load(load),
    .LoadVal(load_val[2:0]), .ClrFlags(clr),
    .Output(out_a), .BinOut(bin_a), .Overflow(ovf_a), .Underflow(unf_a), .Wrap(wrap_a)
  );

  gray_counter_n #(.WIDTH(5), .STICKY(0)) dut_b (
    .Clk(clk), .Reset(rst_n), .En(en), .Dir(dir), .Load(load),
    .LoadVal(load_val), .ClrFlags(clr),
    .Output(out_b), .BinOut(bin_b), .Overflow(ovf_b), .Underflow(unf_b), .Wrap(wrap_b)
  );

  typedef struct {
    int cnt;
    bit ovf;
    bit unf;
    bit wrap;
  } mstate_t;

  mstate_t ma = '{0, 1'b0, 1'b0, 1'b0};
  mstate_t mb = '{0, 1'b0, 1'b0, 1'b0};
  bit      stepped = 1'b0;
  logic [2:0] prev_a;
  logic [4:0] prev_b;

  function automatic int gray_of(int v);
    return v ^ (v >> 1);
  endfunction

  // Decode by searching for the count whose Gray code matches.
  function automatic int gray_decode(int g, int w);
    for (int v = 0; v < (1 << w); v++) begin
      if (gray_of(v) == g) return v;
    end
    return 0;
  endfunction

  function automatic mstate_t mstep(mstate_t s, int w, bit sticky, bit rn, bit ld,
                                    int ldv, bit e, bit d, bit c);
    mstate_t n;
    int modulus;
    bit wu;
    bit wd;
    n = s;
    modulus = 1 << w;
    wu = 1'b0;
    wd = 1'b0;
    if (!rn) begin
      n.cnt = 0; n.ovf = 1'b0; n.unf = 1'b0; n.wrap = 1'b0;
      return n;
    end
    if (ld) begin
      n.cnt = gray_decode(ldv % modulus, w);
    end else if (e && d) begin
      wu = (s.cnt == modulus - 1);
      n.cnt = (s.cnt + 1) % modulus;
    end else if (e) begin
      wd = (s.cnt == 0);
      n.cnt = (s.cnt + modulus - 1) % modulus;
    end
    n.wrap = wu | wd;
    if (sticky) begin
      n.ovf = wu | (s.ovf & !c);
      n.unf = wd | (s.unf & !c);
    end else begin
      n.ovf = wu;
      n.unf = wd;
    end
    return n;
  endfunction

  task automatic check(string name, logic [15:0] act, logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    ma = mstep(ma, 3, 1'b1, rst_n, load, int'(load_val), en, dir, clr);
    mb = mstep(mb, 5, 1'b0, rst_n, load, int'(load_val), en, dir, clr);
    stepped = rst_n && !load && en;
  end

  always @(negedge clk) begin
    check("A.Output",    out_a,  16'(gray_of(ma.cnt)));
    check("A.BinOut",    bin_a,  16'(ma.cnt));
    check("A.Overflow",  ovf_a,  16'(ma.ovf));
    check("A.Underflow", unf_a,  16'(ma.unf));
    check("A.Wrap",      wrap_a, 16'(ma.wrap));
    check("B.Output",    out_b,  16'(gray_of(mb.cnt)));
    check("B.BinOut",    bin_b,  16'(mb.cnt));
    check("B.Overflow",  ovf_b,  16'(mb.ovf));
    check("B.Underflow", unf_b,  16'(mb.unf));
    check("B.Wrap",      wrap_b, 16'(mb.wrap));
    if (stepped) begin
      check("A.one_bit_step", 16'($countones(out_a ^ prev_a)), 16'd1);
      check("B.one_bit_step", 16'($countones(out_b ^ prev_b)), 16'd1);
    end
    prev_a = out_a;
    prev_b = out_b;
  end

  task automatic edge_go();
    @(posedge clk);
    #1;
  endtask

  logic [2:0] up_seq [8];
  int ovf_cnt;
  int wrap_at_ovf;

  initial begin
    up_seq = '{3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100, 3'b000};
    rst_n = 1'b0; en = 1'b0; dir = 1'b1; load = 1'b0; clr = 1'b0; load_val = '0;
    edge_go();
    edge_go();
    check("rst.Output", out_a, 16'd0);
    check("rst.flags",  {ovf_a, unf_a, wrap_a}, 16'd0);

    rst_n = 1'b1; en = 1'b1; dir = 1'b1;
    for (int i = 0; i < 8; i++) begin
      edge_go();
      check($sformatf("up_seq[%0d]", i), out_a, up_seq[i]);
    end
    check("up_wrap.Wrap",      wrap_a, 16'd1);
    check("up_wrap.Overflow",  ovf_a,  16'd1);
    check("up_wrap.Underflow", unf_a,  16'd0);

    dir = 1'b0;
    edge_go();
    check("down_wrap.Output",   out_a, 16'h4);
    check("down_wrap.BinOut",   bin_a, 16'h7);
    check("down_wrap.Wrap",     wrap_a, 16'd1);
    check("down_wrap.flags",    {ovf_a, unf_a}, 16'h3);

    dir = 1'b1; clr = 1'b1;
    edge_go();
    check("clr_vs_wrap.Output", out_a, 16'd0);
    check("clr_vs_wrap.flags",  {ovf_a, unf_a}, 16'h2);

    clr = 1'b0; dir = 1'b0;
    edge_go();
    en = 1'b0; clr = 1'b1;
    edge_go();
    check("clr.flags", {ovf_a, unf_a, wrap_a}, 16'd0);

    clr = 1'b0; load = 1'b1; load_val = 5'b00110; en = 1'b1; dir = 1'b1;
    edge_go();
    check("load.Output", out_a, 16'h6);
    check("load.BinOut", bin_a, 16'h4);
    check("load.Wrap",   wrap_a, 16'd0);
    load = 1'b0;
    edge_go();
    check("after_load.Output", out_a, 16'h7);

    repeat (3) edge_go();
    check("pre_reset.Overflow", ovf_a, 16'd1);
    rst_n = 1'b0; load = 1'b1; en = 1'b1;
    edge_go();
    check("mid_reset.Output", out_a, 16'd0);
    check("mid_reset.flags",  {ovf_a, unf_a, wrap_a}, 16'd0);

    rst_n = 1'b1; load = 1'b0; en = 1'b1; dir = 1'b1;
    repeat (8) edge_go();
    dir = 1'b0;
    repeat (8) edge_go();

    for (int i = 0; i < 400; i++) begin
      rst_n    = ($urandom_range(0, 31) != 0);
      load     = ($urandom_range(0, 7) == 0);
      en       = ($urandom_range(0, 3) != 0);
      dir      = $urandom_range(0, 1);
      clr      = ($urandom_range(0, 7) == 0);
      load_val = 5'($urandom_range(0, 31));
      edge_go();
    end

    rst_n = 1'b0; load = 1'b0; en = 1'b0; clr = 1'b0;
    edge_go();
    rst_n = 1'b1; en = 1'b1; dir = 1'b1;
    ovf_cnt = 0;
    wrap_at_ovf = 0;
    for (int i = 0; i < 32; i++) begin
      edge_go();
      if (ovf_b) begin
        ovf_cnt++;
        if (wrap_b) wrap_at_ovf++;
      end
    end
    check("B.ovf_pulses",   16'(ovf_cnt), 16'd1);
    check("B.ovf_and_wrap", 16'(wrap_at_ovf), 16'd1);
    check("B.wrap_Output",  out_b, 16'd0);
    en = 1'b0;
    edge_go();
    check("B.ovf_cleared",  ovf_b, 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
